// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: N-channel arbiter onto a byte-wide synchronous RAM/IO bus.
// Multi-byte little-endian reads/writes, fixed or round-robin priority, flush.
module mem_arbiter_nch #(
    parameter int                NUM_CH     = 3,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_BYTES = 4,
    parameter bit                RR_MODE    = 1'b0,
    parameter logic [ADDR_W-1:0] IO_BASE    = 'h30000,
    localparam int               CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int               DW = 8 * DATA_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clear,
    input  logic                     io_buffer_full,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH-1:0]        ch_sign,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*3-1:0]      ch_size,
    input  logic [NUM_CH*DW-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [DW-1:0]            rdata,
    output logic                     busy,
    output logic [CW-1:0]            cur_ch,
    output logic [ADDR_W-1:0]        mem_a,
    output logic [7:0]               mem_dout,
    output logic                     mem_wr,
    input  logic [7:0]               mem_din
);

    localparam int KW = $clog2(DATA_BYTES + 2);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t                        state;
    logic [KW-1:0]                 cnt;
    logic [KW-1:0]                 sz;
    logic [ADDR_W-1:0]             base;
    logic [DW-1:0]                 wbuf;
    logic [DATA_BYTES-1:0][7:0]    rbuf;
    logic                          sgn;
    logic [CW-1:0]                 ptr;

    logic [NUM_CH-1:0]             elig;
    logic [CW-1:0]                 win;
    logic                          win_ok;
    logic [ADDR_W-1:0]             w_addr;
    logic [2:0]                    w_size;
    logic [DW-1:0]                 w_wdata;
    logic [KW-1:0]                 ie;
    logic [KW-1:0]                 sz1;
    logic [DATA_BYTES-1:0][7:0]    asm_b;
    logic                          msb;
    logic [DW-1:0]                 rfinal;

    // Sizes other than 1/2/4 that fit the bus collapse to the full width.
    function automatic logic [KW-1:0] legal_size(input logic [2:0] s);
        if ((s == 3'd1 || s == 3'd2 || s == 3'd4) && int'(s) <= DATA_BYTES)
            return KW'(s);
        return KW'(DATA_BYTES);
    endfunction

    assign w_addr  = ch_addr[int'(win)*ADDR_W +: ADDR_W];
    assign w_size  = ch_size[int'(win)*3 +: 3];
    assign w_wdata = ch_wdata[int'(win)*DW +: DW];
    assign ie      = cnt + KW'(1);
    assign sz1     = sz + KW'(1);

    // Eligible requesters: IO-space writes are held back while the UART is full.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = ch_req[i] & ~(ch_we[i] & io_buffer_full &
                      (ch_addr[i*ADDR_W +: ADDR_W] >= IO_BASE));
        end
    end

    // Winner pick: lowest index, or first eligible after the rotating pointer.
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (RR_MODE) begin
                if (!win_ok && elig[(int'(ptr) + 1 + i) % NUM_CH]) begin
                    win    = CW'((int'(ptr) + 1 + i) % NUM_CH);
                    win_ok = 1'b1;
                end
            end else if (!win_ok && elig[i]) begin
                win    = CW'(i);
                win_ok = 1'b1;
            end
        end
    end

    // Final read word: last byte comes straight from the bus, then extend.
    always_comb begin
        asm_b  = rbuf;
        msb    = 1'b0;
        rfinal = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (b == int'(sz) - 1) begin
                asm_b[b] = mem_din;
                msb      = mem_din[7];
            end
        end
        for (int b = 0; b < DATA_BYTES; b++) begin
            rfinal[8*b +: 8] = (b < int'(sz)) ? asm_b[b] : {8{sgn & msb}};
        end
    end

    // Arbitration and bus sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sz       <= '0;
            base     <= '0;
            wbuf     <= '0;
            rbuf     <= '0;
            sgn      <= 1'b0;
            ptr      <= CW'(NUM_CH - 1);
            ch_ack   <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            cur_ch   <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
        end else if (rdy) begin
            ch_ack <= '0;
            unique case (state)
                IDLE: begin
                    if (win_ok && !clear) begin
                        busy   <= 1'b1;
                        cur_ch <= win;
                        mem_a  <= w_addr;
                        base   <= w_addr;
                        cnt    <= '0;
                        sz     <= legal_size(w_size);
                        wbuf   <= w_wdata;
                        sgn    <= ch_sign[win];
                        if (RR_MODE)
                            ptr <= win;
                        if (ch_we[win]) begin
                            mem_wr   <= 1'b1;
                            mem_dout <= w_wdata[7:0];
                            state    <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (clear) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= ie;
                        if (ie < sz)
                            mem_a <= base + ADDR_W'(ie);
                        for (int b = 0; b < DATA_BYTES; b++) begin
                            if (int'(ie) - 2 == b)
                                rbuf[b] <= mem_din;
                        end
                        if (ie == sz1) begin
                            rdata          <= rfinal;
                            ch_ack[cur_ch] <= 1'b1;
                            busy           <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    cnt <= ie;
                    if (ie < sz) begin
                        mem_a <= base + ADDR_W'(ie);
                        for (int b = 0; b < DATA_BYTES; b++) begin
                            if (int'(ie) == b)
                                mem_dout <= wbuf[8*b +: 8];
                        end
                    end else begin
                        mem_wr         <= 1'b0;
                        ch_ack[cur_ch] <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
